demux4x1_tdm: RTL and testbench

Time-division 1-to-4 demultiplexer: the receiving end of a link where a 4:1 mux serializes four channels onto one data path, one channel per valid beat, channel 0 marked by a frame-sync flag. The block locks to the frame sync and tracks the channel slot with a 2-bit counter. It stages each beat into the matching channel and presents all four channel words together, atomically, once a full frame has arrived. It sits between the serial link input and the per-channel consumers.

---
 rtl/demux4x1_tdm.sv | 141 ++++++++++++++
 tb/tb_demux4x1_tdm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux4x1_tdm.sv
// Time-division 1-to-4 demultiplexer: locks to a frame-sync flag, stages the
// serial beats per channel and publishes a complete four-word frame atomically.
module demux4x1_tdm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err,
    output logic [7:0]       frame_count
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       slot_q;
    logic [1:0]       slot_d;
    logic             frame_valid_q;
    logic             sync_err_q;
    logic [7:0]       frame_count_q;
    logic [7:0]       frame_count_d;
    logic [WIDTH-1:0] stage_q [0:2];
    logic [WIDTH-1:0] out_q   [0:3];

    // Beat classification, decoded once and shared by the stage, output and FSM logic.
    logic is_locked;
    logic sync_beat_d;
    logic data_beat_d;
    logic start_d;
    logic mid_d;
    logic complete_d;
    logic misalign_d;

    always_comb begin
        is_locked     = (state_q == LOCKED);
        sync_beat_d   = din_valid && frame_sync;
        data_beat_d   = is_locked && din_valid && !frame_sync;
        start_d       = sync_beat_d || (data_beat_d && (slot_q == 2'd0));
        mid_d         = data_beat_d && ((slot_q == 2'd1) || (slot_q == 2'd2));
        complete_d    = data_beat_d && (slot_q == 2'd3);
        misalign_d    = is_locked && sync_beat_d && (slot_q != 2'd0);
        slot_d        = slot_q + 2'd1;
        frame_count_d = frame_count_q + 8'd1;
    end

    // Channel 0 staging is loaded on every frame start (sync or free-running).
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
        logic load_d;
        if (gi == 0) begin : g_first
            assign load_d = start_d;
        end else begin : g_rest
            assign load_d = mid_d && (slot_q == 2'(gi));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q[gi] <= '0;
            end else if (load_d) begin
                stage_q[gi] <= din;
            end
        end
    end

    // Outputs only move on the completing beat, so consumers never see a torn frame.
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
        logic [WIDTH-1:0] src_d;
        if (gi == 3) begin : g_last
            assign src_d = din;
        end else begin : g_staged
            assign src_d = stage_q[gi];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_q[gi] <= '0;
            end else if (complete_d) begin
                out_q[gi] <= src_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (sync_beat_d) begin
                        state_q <= LOCKED;
                        slot_q  <= 2'd1;
                    end
                end
                LOCKED: begin
                    if (sync_beat_d) begin
                        slot_q     <= 2'd1;
                        sync_err_q <= misalign_d;
                    end else if (complete_d) begin
                        slot_q        <= 2'd0;
                        frame_valid_q <= 1'b1;
                        frame_count_q <= frame_count_d;
                    end else if (data_beat_d) begin
                        slot_q <= slot_d;
                    end
                end
                default: begin
                    state_q <= HUNT;
                    slot_q  <= 2'd0;
                end
            endcase
        end
    end

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_demux4x1_tdm.sv
// Bench for demux4x1_tdm: directed scenarios plus random beats, checked every
// cycle against a queue-based model of the frame assembly rules.
module tb_demux4x1_tdm;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] out0, out1, out2, out3;
    logic             frame_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             sync_err;
    logic [7:0]       frame_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a partial frame is just the list of words received so far.
    bit         m_locked;
    logic [7:0] m_part [$];
    logic [7:0] m_out [4];
    bit         m_fv;
    bit         m_se;
    int         m_cnt;

    demux4x1_tdm #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_part.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_fv  = 0;
        m_se  = 0;
        m_cnt = 0;
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [7:0] d);
        m_fv = 0;
        m_se = 0;
        if (!v) return;
        if (s) begin
            if (m_locked && m_part.size() != 0) m_se = 1;
            m_locked = 1;
            m_part.delete();
            m_part.push_back(d);
        end else if (m_locked) begin
            m_part.push_back(d);
            if (m_part.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_part[i];
                m_part.delete();
                m_fv  = 1;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".out0"}, 32'(out0), 32'(m_out[0]));
        chk({ctx, ".out1"}, 32'(out1), 32'(m_out[1]));
        chk({ctx, ".out2"}, 32'(out2), 32'(m_out[2]));
        chk({ctx, ".out3"}, 32'(out3), 32'(m_out[3]));
        chk({ctx, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
        chk({ctx, ".sync_err"}, 32'(sync_err), 32'(m_se));
        chk({ctx, ".slot"}, 32'(slot), 32'(m_part.size()));
        chk({ctx, ".locked"}, 32'(locked), 32'(m_locked));
        chk({ctx, ".frame_count"}, 32'(frame_count), 32'(m_cnt));
    endtask

    task automatic beat(input string ctx, input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        rst        = 1'b0;
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        model_beat(v, s, d);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        rst        = 1'b1;
        din_valid  = 1'b1;
        frame_sync = 1'b1;
        din        = 8'hEE;
        @(posedge clk);
        model_reset();
        #1;
        check_all(ctx);
        @(negedge clk);
        rst = 1'b0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        frame_sync = 1'b0;
        model_reset();

        // Reset state
        do_reset("reset");

        // Basic frame A0..A3 with sync on first beat
        beat("basic", 1, 1, 8'hA0);
        beat("basic", 1, 0, 8'hA1);
        beat("basic", 1, 0, 8'hA2);
        beat("basic", 1, 0, 8'hA3);
        chk("basic.fv_pulse", 32'(frame_valid), 32'd1);
        chk("basic.count1", 32'(frame_count), 32'd1);
        beat("basic.idle", 0, 0, 8'h00);
        chk("basic.fv_one_cycle", 32'(frame_valid), 32'd0);

        // Hunt discards unsynced beats
        do_reset("hunt.reset");
        beat("hunt", 1, 0, 8'h11);
        beat("hunt", 1, 0, 8'h22);
        chk("hunt.not_locked", 32'(locked), 32'd0);
        beat("hunt", 1, 1, 8'h01);
        beat("hunt", 1, 0, 8'h02);
        beat("hunt", 1, 0, 8'h03);
        beat("hunt", 1, 0, 8'h04);
        chk("hunt.out_frame", {out0, out1, out2, out3}, 32'h01020304);

        // Back-to-back frames, sync only on first beat overall
        for (int i = 0; i < 8; i++)
            beat("b2b", 1, (i == 0), 8'h30 + 8'(i));
        chk("b2b.out3_second", 32'(out3), 32'h37);

        // Gaps with frame_sync toggling while invalid
        for (int i = 0; i < 4; i++) begin
            beat("gap", 1, (i == 0), 8'h50 + 8'(i));
            beat("gap.idle", 0, 1, 8'hFF);
            beat("gap.idle", 0, (i % 2 == 0), 8'hAA);
        end
        chk("gap.out_frame", {out0, out1, out2, out3}, 32'h50515253);

        // Misplaced sync at slot 2
        beat("resync", 1, 1, 8'h60);
        beat("resync", 1, 0, 8'h61);
        beat("resync", 1, 1, 8'h70);
        chk("resync.sync_err", 32'(sync_err), 32'd1);
        chk("resync.slot", 32'(slot), 32'd1);
        beat("resync", 1, 0, 8'h71);
        beat("resync", 1, 0, 8'h72);
        beat("resync", 1, 0, 8'h73);
        chk("resync.out_frame", {out0, out1, out2, out3}, 32'h70717273);

        // Reset mid-frame, then a clean frame
        beat("midrst", 1, 1, 8'h80);
        beat("midrst", 1, 0, 8'h81);
        do_reset("midrst.reset");
        chk("midrst.out_zero", {out0, out1, out2, out3}, 32'h0);
        beat("midrst", 1, 1, 8'h90);
        beat("midrst", 1, 0, 8'h91);
        beat("midrst", 1, 0, 8'h92);
        beat("midrst", 1, 0, 8'h93);
        chk("midrst.count", 32'(frame_count), 32'd1);

        // Randomized beats
        for (int i = 0; i < 400; i++)
            beat("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                 8'($urandom));

        // Frame counter wrap
        do_reset("wrap.reset");
        for (int f = 0; f < 256; f++)
            for (int b = 0; b < 4; b++)
                beat("wrap", 1, (f == 0 && b == 0), 8'($urandom));
        chk("wrap.count_zero", 32'(frame_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
